// File: rtl/hp_word_timer_if.sv
// rtl/hp_word_timer_if.sv - control inputs and timing outputs of hp_word_timer
`timescale 1ns/1ps
interface hp_word_timer_if #(
    parameter int CNT_W  = 6,
    parameter int WCNT_W = 16
);
    logic              run;
    logic              ext_sync;
    logic [CNT_W-3:0]  field_lo;
    logic [CNT_W-3:0]  field_hi;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-3:0]  digit;
    logic [1:0]        bit_in_digit;
    logic              sync;
    logic              word_start;
    logic              field_en;
    logic              busy;
    logic [WCNT_W-1:0] word_cnt;
    logic              locked;

    modport master (
        output run, ext_sync, field_lo, field_hi,
        input  bit_cnt, digit, bit_in_digit, sync, word_start, field_en,
               busy, word_cnt, locked
    );

    modport slave (
        input  run, ext_sync, field_lo, field_hi,
        output bit_cnt, digit, bit_in_digit, sync, word_start, field_en,
               busy, word_cnt, locked
    );
endinterface

// File: rtl/hp_word_timer.sv
// rtl/hp_word_timer.sv - bit-serial word timing sequencer with run/stop control
// Optional external sync realignment is built when HP_SYNC_LOCK_EN is defined.
`timescale 1ns/1ps
module hp_word_timer #(
    parameter int WORD_LEN   = 56,
    parameter int SYNC_START = 45,
    parameter int SYNC_LEN   = 10,
    parameter int CNT_W      = 6,
    parameter int WCNT_W     = 16
) (
    input  logic           clk,
    input  logic           rst,
    hp_word_timer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_LEN - 1);
    localparam logic [CNT_W-1:0] SYNC_LO  = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] SYNC_HI  = CNT_W'(SYNC_START + SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] JUMP_TO  =
        (SYNC_START + 1 == WORD_LEN) ? '0 : CNT_W'(SYNC_START + 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_nxt;
    logic [WCNT_W-1:0] word_cnt;
    logic              active;
    logic              jump;
    logic              wrap;

    assign active = (state == RUN) || (state == STOPPING);
    // A realignment jump replaces the normal end-of-word wrap for that cycle.
    assign wrap   = (bit_cnt == LAST_BIT) && !jump;

`ifdef HP_SYNC_LOCK_EN
    logic ext_q;
    logic ext_prev;
    logic edge_seen;
    logic locked_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q    <= 1'b0;
            ext_prev <= 1'b0;
        end else begin
            ext_q    <= bus.ext_sync;
            ext_prev <= ext_q;
        end
    end

    assign edge_seen = ext_q & ~ext_prev;
    assign jump      = active && edge_seen && (bit_cnt != SYNC_LO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_r <= 1'b0;
        end else if (state_nxt == IDLE) begin
            locked_r <= 1'b0;
        end else if (active && edge_seen) begin
            locked_r <= (bit_cnt == SYNC_LO);
        end
    end

    assign bus.locked = locked_r;
`else
    assign jump       = 1'b0;
    assign bus.locked = active;
`endif

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        case (state)
            IDLE: begin
                bit_nxt = '0;
                if (bus.run) begin
                    state_nxt = RUN;
                end
            end
            RUN, STOPPING: begin
                if (jump) begin
                    bit_nxt = JUMP_TO;
                end else if (wrap) begin
                    bit_nxt = '0;
                end else begin
                    bit_nxt = bit_cnt + CNT_W'(1);
                end
                // Reasserted run keeps the current word going rather than restarting it.
                if (bus.run) begin
                    state_nxt = RUN;
                end else if (wrap) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = STOPPING;
                end
            end
            default: begin
                state_nxt = IDLE;
                bit_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (active && wrap) begin
            word_cnt <= word_cnt + WCNT_W'(1);
        end
    end

    assign bus.bit_cnt      = bit_cnt;
    assign bus.digit        = bit_cnt[CNT_W-1:2];
    assign bus.bit_in_digit = bit_cnt[1:0];
    assign bus.sync         = active && (bit_cnt >= SYNC_LO) && (bit_cnt <= SYNC_HI);
    assign bus.word_start   = active && (bit_cnt == '0);
    assign bus.field_en     = active && (bus.field_lo <= bit_cnt[CNT_W-1:2])
                                     && (bit_cnt[CNT_W-1:2] <= bus.field_hi);
    assign bus.busy         = active;
    assign bus.word_cnt     = word_cnt;

endmodule

// File: tb/tb_hp_word_timer.sv
// tb/tb_hp_word_timer.sv - self-checking bench for hp_word_timer
`timescale 1ns/1ps
module tb_hp_word_timer;

    localparam int WL = 56;
    localparam int SS = 45;
    localparam int SL = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run_v = 1'b0;
    logic ext_v = 1'b0;
    logic [3:0] flo = 4'd3;
    logic [3:0] fhi = 4'd5;

    int errors = 0;
    int checks = 0;

    // reference state: whether words are being sequenced, position in word, words completed
    bit m_active;
    int m_pos;
    int m_words;
    bit m_lock;
    bit s0, s1;

    hp_word_timer_if #(.CNT_W(6), .WCNT_W(16)) bus ();
    hp_word_timer_if #(.CNT_W(6), .WCNT_W(4))  bus2 ();

    assign bus.run       = run_v;
    assign bus.ext_sync  = ext_v;
    assign bus.field_lo  = flo;
    assign bus.field_hi  = fhi;
    assign bus2.run      = run_v;
    assign bus2.ext_sync = ext_v;
    assign bus2.field_lo = flo;
    assign bus2.field_hi = fhi;

    hp_word_timer #(.WORD_LEN(WL), .SYNC_START(SS), .SYNC_LEN(SL), .CNT_W(6), .WCNT_W(16))
        dut (.clk(clk), .rst(rst), .bus(bus));
    hp_word_timer #(.WORD_LEN(WL), .SYNC_START(SS), .SYNC_LEN(SL), .CNT_W(6), .WCNT_W(4))
        dut4 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0] lo;
        logic [3:0] hi;
        int         n_en;
        int         first_bit;
        int         last_bit;
    } field_vec_t;

    field_vec_t fv [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_pos = 0; m_words = 0; m_lock = 0; s0 = 0; s1 = 0;
    endtask

    task automatic model_step(input bit r, input bit e);
        bit ed, jmp, lst;
        ed  = 1'b0;
        jmp = 1'b0;
`ifdef HP_SYNC_LOCK_EN
        ed = s1 && !s0;
`endif
        if (m_active) begin
            if (ed) begin
                if (m_pos == SS) m_lock = 1;
                else begin m_lock = 0; jmp = 1; end
            end
            lst = (m_pos == WL - 1) && !jmp;
            if (lst) m_words++;
            if (jmp) m_pos = (SS + 1 == WL) ? 0 : SS + 1;
            else     m_pos = (m_pos + 1) % WL;
            if (!r && lst) begin m_active = 0; m_lock = 0; end
        end else if (r) begin
            m_active = 1;
        end
        s0 = s1;
        s1 = e;
    endtask

    task automatic check_all();
        int d;
        bit exp_lock;
        d = m_pos / 4;
`ifdef HP_SYNC_LOCK_EN
        exp_lock = m_lock;
`else
        exp_lock = m_active;
`endif
        chk("bit_cnt", int'(bus.bit_cnt), m_pos);
        chk("digit", int'(bus.digit), d);
        chk("bit_in_digit", int'(bus.bit_in_digit), m_pos % 4);
        chk("sync", int'(bus.sync), int'(m_active && m_pos >= SS && m_pos < SS + SL));
        chk("word_start", int'(bus.word_start), int'(m_active && m_pos == 0));
        chk("field_en", int'(bus.field_en), int'(m_active && int'(flo) <= d && d <= int'(fhi)));
        chk("busy", int'(bus.busy), int'(m_active));
        chk("word_cnt", int'(bus.word_cnt), m_words % 65536);
        chk("word_cnt4", int'(bus2.word_cnt), m_words % 16);
        chk("locked", int'(bus.locked), int'(exp_lock));
    endtask

    task automatic step();
        @(posedge clk);
        model_step(run_v, ext_v);
        #2;
        check_all();
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #2;
        check_all();
        chk({name, "_bit"}, int'(bus.bit_cnt), 0);
        chk({name, "_wc"}, int'(bus.word_cnt), 0);
        chk({name, "_busy"}, int'(bus.busy), 0);
        chk({name, "_sync"}, int'(bus.sync), 0);
        chk({name, "_locked"}, int'(bus.locked), 0);
        rst = 1'b0;
    endtask

    task automatic step_until(input int pos, input string name);
        int n;
        n = 0;
        while (m_pos != pos && n < 200) begin step(); n++; end
        if (m_pos != pos) chk(name, m_pos, pos);
    endtask

    initial begin
        int ws_cnt, sync_cnt, since_ws, n, wc0, cnt, first, last;
        bit prev_sync;

        fv[0] = '{4'd3,  4'd5,  12, 12, 23};
        fv[1] = '{4'd9,  4'd2,   0, -1, -1};
        fv[2] = '{4'd0,  4'd13, 56,  0, 55};
        fv[3] = '{4'd13, 4'd13,  4, 52, 55};
        fv[4] = '{4'd7,  4'd7,   4, 28, 31};
        fv[5] = '{4'd0,  4'd0,   4,  0,  3};

        model_reset();
        #1;
        do_reset("reset");

        // free run for 200 cycles
        run_v = 1'b1;
        step();
        chk("latency_busy", int'(bus.busy), 1);
        chk("latency_ws", int'(bus.word_start), 1);
        ws_cnt = 1; sync_cnt = 0; since_ws = 0; prev_sync = 0;
        for (int i = 0; i < 199; i++) begin
            step();
            since_ws++;
            if (bus.word_start) begin ws_cnt++; since_ws = 0; end
            if (bus.sync) sync_cnt++;
            if (bus.sync && !prev_sync) chk("sync_rise", since_ws, SS);
            prev_sync = bus.sync;
            if (i == 167) chk("wc3", int'(bus.word_cnt), 3);
        end
        chk("ws_count", ws_cnt, 4);
        chk("sync_count", sync_cnt, 30);

        // stop request mid-word
        step_until(20, "reach20");
        wc0 = m_words;
        run_v = 1'b0;
        n = 0;
        do begin step(); n++; end while (bus.busy && n < 80);
        chk("stop_cycles", n, 36);
        chk("stop_wc", int'(bus.word_cnt), wc0 + 1);
        chk("stop_bit", int'(bus.bit_cnt), 0);

        // field window table
        run_v = 1'b1;
        step();
        step_until(55, "reach55");
        for (int t = 0; t < 6; t++) begin
            flo = fv[t].lo;
            fhi = fv[t].hi;
            cnt = 0; first = -1; last = -1;
            for (int k = 0; k < WL; k++) begin
                step();
                if (bus.field_en) begin
                    cnt++;
                    if (first < 0) first = int'(bus.bit_cnt);
                    last = int'(bus.bit_cnt);
                end
            end
            chk("field_n", cnt, fv[t].n_en);
            chk("field_first", first, fv[t].first_bit);
            chk("field_last", last, fv[t].last_bit);
        end
        flo = 4'd3; fhi = 4'd5;

        // 4-bit word counter wrap
        do_reset("reset2");
        step();
        for (int i = 0; i < 17 * WL; i++) step();
        chk("wrap16", int'(bus2.word_cnt), 1);
        chk("wc17", int'(bus.word_cnt), 17);

        // reset mid-word
        step_until(30, "reach30");
        do_reset("midreset");

`ifdef HP_SYNC_LOCK_EN
        step();
        step_until(44, "lock44a");
        ext_v = 1'b1; step();
        ext_v = 1'b0; step();
        chk("lock_set", int'(bus.locked), 1);
        step_until(9, "lock9");
        ext_v = 1'b1; step();
        ext_v = 1'b0; step();
        chk("realign_bit", int'(bus.bit_cnt), SS + 1);
        chk("lock_clr", int'(bus.locked), 0);
        step_until(44, "lock44b");
        ext_v = 1'b1; step();
        ext_v = 1'b0; step();
        chk("relock", int'(bus.locked), 1);
`endif

        // randomized run/stop, field and ext_sync activity against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom % 20 == 0) run_v = ~run_v;
            ext_v = ($urandom % 17 == 0);
            if ($urandom % 50 == 0) begin
                flo = 4'($urandom % 16);
                fhi = 4'($urandom % 16);
            end
            if ($urandom % 400 == 0) do_reset("rnd_reset");
            else step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
